// File: rtl/nibble_link_arbiter.sv
// Arbitrates N_REQ word sources onto one nibble serializer and tracks the
// transfer by counting. Define ARB_ROUND_ROBIN_EN for round-robin, else fixed priority.
module nibble_link_arbiter #(
  parameter int N_REQ  = 4,
  parameter int WORD_W = 24,
  parameter int LINK_W = 4,
  parameter int GAP    = 1,
  localparam int SRC_W = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*WORD_W-1:0] data_in,
  output logic [N_REQ-1:0]        ack,
  output logic                    buf_write,
  output logic [WORD_W-1:0]       buf_in,
  output logic [SRC_W-1:0]        cur_src,
  output logic                    busy,
  output logic                    tx_done
);
  localparam int NIBBLES = WORD_W / LINK_W;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [3:0]       GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
  localparam logic [3:0]       GAP_ONE  = 4'd1;

  if (WORD_W % LINK_W != 0) begin : g_bad_width
    $error("nibble_link_arbiter: WORD_W must be a multiple of LINK_W");
  end
  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
    $error("nibble_link_arbiter: N_REQ must be 2..8");
  end
  if (GAP < 0 || GAP > 15) begin : g_bad_gap
    $error("nibble_link_arbiter: GAP must be 0..15");
  end

  typedef enum logic [1:0] {IDLE, LAUNCH, SEND, GAP_ST} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [3:0]        gcnt;
  logic [SRC_W-1:0]  win;
  logic [WORD_W-1:0] words [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_words
    assign words[i] = data_in[i*WORD_W +: WORD_W];
  end

`ifdef ARB_ROUND_ROBIN_EN
  logic [SRC_W-1:0] ptr;

  // Lowest requester above ptr wins; if none, wrap to the lowest overall.
  always_comb begin
    win = '0;
    for (int i = N_REQ-1; i >= 0; i--)
      if (req[i]) win = SRC_W'(i);
    for (int i = N_REQ-1; i >= 0; i--)
      if (req[i] && SRC_W'(i) > ptr) win = SRC_W'(i);
  end
`else
  always_comb begin
    win = '0;
    for (int i = N_REQ-1; i >= 0; i--)
      if (req[i]) win = SRC_W'(i);
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      gcnt      <= '0;
      ack       <= '0;
      buf_write <= 1'b0;
      buf_in    <= '0;
      cur_src   <= '0;
      busy      <= 1'b0;
      tx_done   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr       <= SRC_W'(N_REQ - 1);
`endif
    end else begin
      ack       <= '0;
      buf_write <= 1'b0;
      tx_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            state     <= LAUNCH;
            buf_in    <= words[win];
            cur_src   <= win;
            ack[win]  <= 1'b1;
            buf_write <= 1'b1;
            busy      <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            ptr       <= win;
`endif
          end
        end
        LAUNCH: begin
          state   <= SEND;
          cnt     <= '0;
          tx_done <= (NIBBLES == 1);
        end
        SEND: begin
          if (cnt == CNT_LAST) begin
            busy <= 1'b0;
            if (GAP > 0) begin
              state <= GAP_ST;
              gcnt  <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt     <= cnt + CNT_ONE;
            // registered pulse lands in the cycle where cnt reads NIBBLES-1
            tx_done <= ((cnt + CNT_ONE) == CNT_LAST);
          end
        end
        GAP_ST: begin
          if (gcnt == GAP_LAST) state <= IDLE;
          else                  gcnt  <= gcnt + GAP_ONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/nibble_link_arbiter.md
Name: nibble_link_arbiter

Overview:
- Shares the single 4-bit nibble serial link, made of the 24-bit-word serializer and its deserializer, between several 24-bit word sources such as encoder channels.
- Arbitrates pending requests and loads the winner's word into the serializer with a one-cycle write pulse.
- Tracks the serializer's nibble transfer by counting, enforces an inter-word gap, and reports the active source ID so the receive side can demultiplex.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- WORD_W, 24, word width; must be a multiple of LINK_W
- LINK_W, 4, serial link width; NIBBLES = WORD_W/LINK_W (6 at defaults)
- GAP, 1, idle cycles inserted after each transfer (0..15)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  N_REQ  per-source request; held high until its ack
- data_in  in  N_REQ*WORD_W  packed source words; source i at bits [i*WORD_W +: WORD_W]
- ack  out  N_REQ  one-cycle pulse: source's word accepted
- buf_write  out  1  one-cycle write strobe to the serializer
- buf_in  out  WORD_W  word presented to the serializer
- cur_src  out  clog2(N_REQ)  ID of the source owning the link
- busy  out  1  high from the launch cycle through the last SEND cycle
- tx_done  out  1  one-cycle pulse in the last SEND cycle

Behaviour:
- Reset (reset=0, async):
  - State=IDLE.
  - ack=0, buf_write=0, buf_in=0, cur_src=0, busy=0, tx_done=0, counters=0.
  - Round-robin pointer = N_REQ-1, so the first search starts at source 0.
- All outputs are registered.
- IDLE:
  - If |req, pick winner w by the arbitration rule.
  - Next edge: state=LAUNCH, buf_in=data_in[w], cur_src=w, ack[w]=1, buf_write=1, busy=1.
- LAUNCH (1 cycle):
  - buf_write and ack are high this cycle only.
  - Next edge: state=SEND, cnt=0.
- SEND (NIBBLES cycles):
  - cnt increments each cycle.
  - tx_done=1 in the cycle where cnt==NIBBLES-1.
  - Next edge: GAP if GAP>0, else IDLE. busy drops at this edge.
- GAP (GAP cycles):
  - No arbitration; then IDLE.
- Timing:
  - Launch-to-launch minimum = 1+NIBBLES+GAP+1 (9 at defaults).
  - Latency from req sampled high in IDLE to buf_write high = 1 cycle.
- buf_in and cur_src hold their value from launch until the next launch; they are stable through SEND and GAP.
- Requester contract:
  - data_in[i] stable while req[i] high.
  - Source drops req in the cycle after its ack. Req still high in the next IDLE is a new word.
- req changes during LAUNCH, SEND or GAP are ignored; only IDLE samples req.
- Pointer updates to w on every grant.
- Reset mid-transfer: all state cleared immediately. The in-flight word is abandoned, no tx_done, and the source is not re-acked.
- Invalid WORD_W%LINK_W!=0: elaboration error.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN
- Defined: round-robin arbitration. Search starts at pointer+1 mod N_REQ; the first requesting source wins.
- Undefined: fixed priority, lowest index wins. The pointer register is not built.

Test Plan:
1. Single request, defaults: req=4'b0100, data_in[2]=24'hB98EA1, req held high until the ack cycle → expected outputs:
   - one cycle after req is sampled: buf_write=1, ack=4'b0100, buf_in=24'hB98EA1, cur_src=2;
   - tx_done 6 cycles after buf_write;
   - busy high for 7 cycles;
   - no second write.
2. Continuous contention, RR: req=4'b1111 held high throughout (each ack immediately followed by a new request) → launches at 9-cycle spacing; cur_src sequence 0,1,2,3,0.
3. Fixed priority (no macro): req=4'b1011 held high throughout → cur_src sequence 0,0,0; sources 1 and 3 are starved, which is the required fixed-priority behaviour.
4. Late request during SEND: req[1] rises mid-SEND while src 3 transmits → req[1] ignored until IDLE; buf_write for src 1 exactly 1 cycle after the IDLE sample.
5. Reset mid-SEND: reset=0 at cnt=3 → all outputs 0 asynchronously, no tx_done. After release with req=4'b0001, launch 1 cycle later with cur_src=0.
6. GAP=0 override: back-to-back req[0] → launch-to-launch spacing = 8 cycles.
